// File: rtl/hazard_tracker_pkg.sv
// Shared types for the hazard tracker: register-address width, the x0
// constant, and the per-stage control record carried down the pipeline.
package hazard_tracker_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  regwrite_en;
    logic                  is_load;
  } stage_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_reg.sv
// One pipeline-stage control register: async active-low reset plus a
// synchronous clear that turns the next load into a bubble.
module pipe_ctrl_reg
  import hazard_tracker_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  stage_ctrl_t d_i,
  output stage_ctrl_t q_o
);

  stage_ctrl_t state_q;
  stage_ctrl_t state_d;

  assign state_d = clr_i ? '0 : d_i;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q_o = state_q;

endmodule

// File: rtl/hazard_tracker.sv
// Load-use / taken-branch hazard control with ID/EX, EX/MEM and MEM/WB
// destination tracking and saturating stall/flush event counters.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite_en,
  input  logic                  id_is_load,
  input  logic                  ex_pc_src,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [REG_ADDR_W-1:0] ID_EX_rd,
  output logic [REG_ADDR_W-1:0] ID_EX_rs1,
  output logic [REG_ADDR_W-1:0] ID_EX_rs2,
  output logic [REG_ADDR_W-1:0] EX_MEM_rd,
  output logic [REG_ADDR_W-1:0] MEM_WB_rd,
  output logic                  EX_MEM_regwrite_en,
  output logic                  MEM_WB_regwrite_en,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  stage_ctrl_t id_ex_d, id_ex_q;
  stage_ctrl_t ex_mem_d, ex_mem_q;
  stage_ctrl_t mem_wb_d, mem_wb_q;

  logic [REG_ADDR_W-1:0] eff_rs1, eff_rs2;
  logic lw_hit, lw_stall;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  // An empty decode slot reads x0, which can never match a load destination.
  assign eff_rs1 = id_valid ? id_rs1 : X0;
  assign eff_rs2 = id_valid ? id_rs2 : X0;

  assign lw_hit = id_ex_q.is_load && (id_ex_q.rd != X0) &&
                  ((id_ex_q.rd == eff_rs1) || (id_ex_q.rd == eff_rs2));
  assign lw_stall = lw_hit && !ex_pc_src;

  assign stall_f = lw_stall;
  assign stall_d = lw_stall;
  assign flush_d = ex_pc_src;
  assign flush_e = lw_stall || ex_pc_src;

  assign id_ex_d = '{rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                     regwrite_en: id_regwrite_en, is_load: id_is_load};
  assign ex_mem_d = '{rd: id_ex_q.rd, rs1: X0, rs2: X0,
                      regwrite_en: id_ex_q.regwrite_en, is_load: id_ex_q.is_load};
  assign mem_wb_d = '{rd: ex_mem_q.rd, rs1: X0, rs2: X0,
                      regwrite_en: ex_mem_q.regwrite_en, is_load: 1'b0};

  pipe_ctrl_reg u_id_ex (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush_e || !id_valid),
    .d_i   (id_ex_d),
    .q_o   (id_ex_q)
  );

  pipe_ctrl_reg u_ex_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .d_i   (ex_mem_d),
    .q_o   (ex_mem_q)
  );

  pipe_ctrl_reg u_mem_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .d_i   (mem_wb_d),
    .q_o   (mem_wb_q)
  );

  // Fields the later stages carry but nothing downstream reads.
  logic [2*(2*REG_ADDR_W+1)-1:0] stage_unused;
  assign stage_unused = {ex_mem_q.rs1, ex_mem_q.rs2, ex_mem_q.is_load,
                         mem_wb_q.rs1, mem_wb_q.rs2, mem_wb_q.is_load};

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lw_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ex_pc_src && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ID_EX_rd           = id_ex_q.rd;
  assign ID_EX_rs1          = id_ex_q.rs1;
  assign ID_EX_rs2          = id_ex_q.rs2;
  assign EX_MEM_rd          = ex_mem_q.rd;
  assign EX_MEM_regwrite_en = ex_mem_q.regwrite_en;
  assign MEM_WB_rd          = mem_wb_q.rd;
  assign MEM_WB_regwrite_en = mem_wb_q.regwrite_en;
  assign stall_cnt          = stall_cnt_q;
  assign flush_cnt          = flush_cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: load-use, ALU forwarding window, x0,
// branch flush, branch-vs-stall priority, async reset and counter saturation.
module tb_hazard_tracker;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_regwrite_en, id_is_load, ex_pc_src;

  logic       stall_f, stall_d, flush_d, flush_e;
  logic [4:0] ID_EX_rd, ID_EX_rs1, ID_EX_rs2, EX_MEM_rd, MEM_WB_rd;
  logic       EX_MEM_regwrite_en, MEM_WB_regwrite_en;
  logic [31:0] stall_cnt, flush_cnt;

  logic       s_stall_f, s_stall_d, s_flush_d, s_flush_e;
  logic [4:0] s_id_ex_rd, s_id_ex_rs1, s_id_ex_rs2, s_ex_mem_rd, s_mem_wb_rd;
  logic       s_ex_mem_we, s_mem_wb_we;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_tracker #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite_en(id_regwrite_en), .id_is_load(id_is_load), .ex_pc_src(ex_pc_src),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .ID_EX_rd(ID_EX_rd), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2),
    .EX_MEM_rd(EX_MEM_rd), .MEM_WB_rd(MEM_WB_rd),
    .EX_MEM_regwrite_en(EX_MEM_regwrite_en), .MEM_WB_regwrite_en(MEM_WB_regwrite_en),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  hazard_tracker #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite_en(id_regwrite_en), .id_is_load(id_is_load), .ex_pc_src(ex_pc_src),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_d(s_flush_d), .flush_e(s_flush_e),
    .ID_EX_rd(s_id_ex_rd), .ID_EX_rs1(s_id_ex_rs1), .ID_EX_rs2(s_id_ex_rs2),
    .EX_MEM_rd(s_ex_mem_rd), .MEM_WB_rd(s_mem_wb_rd),
    .EX_MEM_regwrite_en(s_ex_mem_we), .MEM_WB_regwrite_en(s_mem_wb_we),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic decode(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic we, input logic ld);
    id_valid       = v;
    id_rd          = rd;
    id_rs1         = rs1;
    id_rs2         = rs2;
    id_regwrite_en = we;
    id_is_load     = ld;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_pc_src = 1'b0;
    decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("reset_stall_f", 32'(stall_f), 32'd0);
    check("reset_flush_e", 32'(flush_e), 32'd0);
    check("reset_id_ex_rd", 32'(ID_EX_rd), 32'd0);
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Load-use: load x5, then a reader of x5.
    decode(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
    #1;
    check("lu_no_stall_before", 32'(stall_f), 32'd0);
    tick();
    check("lu_id_ex_rd_load", 32'(ID_EX_rd), 32'd5);
    decode(1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0);
    #1;
    check("lu_stall_f", 32'(stall_f), 32'd1);
    check("lu_stall_d", 32'(stall_d), 32'd1);
    check("lu_flush_e", 32'(flush_e), 32'd1);
    check("lu_flush_d", 32'(flush_d), 32'd0);
    tick();
    check("lu_bubble_rd", 32'(ID_EX_rd), 32'd0);
    check("lu_ex_mem_rd", 32'(EX_MEM_rd), 32'd5);
    check("lu_stall_cnt", stall_cnt, 32'd1);
    check("lu_stall_once", 32'(stall_f), 32'd0);
    tick();
    check("lu_consumer_in_ex", 32'(ID_EX_rs1), 32'd5);
    check("lu_mem_wb_rd", 32'(MEM_WB_rd), 32'd5);
    check("lu_mem_wb_we", 32'(MEM_WB_regwrite_en), 32'd1);
    check("lu_stall_cnt_hold", stall_cnt, 32'd1);

    // ALU back-to-back: writer of x7, then reader of x7.
    decode(1'b1, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0);
    tick();
    decode(1'b1, 5'd8, 5'd7, 5'd3, 1'b1, 1'b0);
    #1;
    check("alu_no_stall", 32'(stall_f), 32'd0);
    tick();
    check("alu_id_ex_rs1", 32'(ID_EX_rs1), 32'd7);
    check("alu_id_ex_rs2", 32'(ID_EX_rs2), 32'd3);
    check("alu_ex_mem_rd", 32'(EX_MEM_rd), 32'd7);
    check("alu_ex_mem_we", 32'(EX_MEM_regwrite_en), 32'd1);

    // x0 destination load followed by a reader of x0.
    decode(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
    tick();
    decode(1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0);
    #1;
    check("x0_no_stall", 32'(stall_f), 32'd0);
    check("x0_no_flush_e", 32'(flush_e), 32'd0);
    tick();
    check("x0_we_passthru", 32'(EX_MEM_regwrite_en), 32'd1);
    check("x0_ex_mem_rd", 32'(EX_MEM_rd), 32'd0);

    // Invalid decode slot never matches, and loads a bubble.
    decode(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
    tick();
    decode(1'b0, 5'd6, 5'd5, 5'd5, 1'b1, 1'b0);
    #1;
    check("inv_no_stall", 32'(stall_f), 32'd0);
    tick();
    check("inv_bubble_rd", 32'(ID_EX_rd), 32'd0);

    // Taken branch with a valid decode instruction.
    decode(1'b1, 5'd10, 5'd3, 5'd4, 1'b1, 1'b0);
    ex_pc_src = 1'b1;
    #1;
    check("br_flush_d", 32'(flush_d), 32'd1);
    check("br_flush_e", 32'(flush_e), 32'd1);
    check("br_stall_f", 32'(stall_f), 32'd0);
    tick();
    ex_pc_src = 1'b0;
    check("br_id_ex_rd", 32'(ID_EX_rd), 32'd0);
    check("br_id_ex_rs1", 32'(ID_EX_rs1), 32'd0);
    check("br_flush_cnt", flush_cnt, 32'd1);

    // Branch together with a load-use hit: branch wins.
    decode(1'b1, 5'd11, 5'd1, 5'd2, 1'b1, 1'b1);
    tick();
    decode(1'b1, 5'd12, 5'd0, 5'd11, 1'b1, 1'b0);
    ex_pc_src = 1'b1;
    #1;
    check("both_stall_f", 32'(stall_f), 32'd0);
    check("both_stall_d", 32'(stall_d), 32'd0);
    check("both_flush_e", 32'(flush_e), 32'd1);
    tick();
    ex_pc_src = 1'b0;
    check("both_stall_cnt", stall_cnt, 32'd1);
    check("both_flush_cnt", flush_cnt, 32'd2);

    // Reset asserted in the middle of a load-use stall.
    decode(1'b1, 5'd12, 5'd1, 5'd2, 1'b1, 1'b1);
    tick();
    decode(1'b1, 5'd13, 5'd12, 5'd0, 1'b1, 1'b0);
    #1;
    check("rst_pre_stall", 32'(stall_f), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_stall_f", 32'(stall_f), 32'd0);
    check("rst_flush_e", 32'(flush_e), 32'd0);
    check("rst_id_ex_rd", 32'(ID_EX_rd), 32'd0);
    check("rst_ex_mem_rd", 32'(EX_MEM_rd), 32'd0);
    check("rst_ex_mem_we", 32'(EX_MEM_regwrite_en), 32'd0);
    check("rst_mem_wb_we", 32'(MEM_WB_regwrite_en), 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_release_load", 32'(ID_EX_rd), 32'd13);

    // Twenty consecutive taken branches.
    decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ex_pc_src = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    ex_pc_src = 1'b0;
    check("sat_flush_cnt_w4", 32'(s_flush_cnt), 32'd15);
    check("sat_flush_cnt_w32", flush_cnt, 32'd20);
    tick();
    check("sat_flush_cnt_hold", 32'(s_flush_cnt), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
